// File: rtl/srff_pkg.sv
// Shared types and constants for the SR flip-flop initiator and its helpers.
package srff_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_e;

  // {s,r} excitation codes.
  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

endpackage

// File: rtl/srff_excite.sv
// SR excitation: {s,r} that moves a flip-flop from q to tgt.
// Ports: q (current state), tgt (desired state), sr_c ({s,r}, combinational).
// Never produces SR_ILLEGAL; unknown q is treated as a mismatch.
module srff_excite
  import srff_pkg::*;
(
  input  logic       q,
  input  logic       tgt,
  output logic [1:0] sr_c
);

  always_comb begin
    sr_c = SR_HOLD;
    if (q !== tgt) begin
      sr_c = tgt ? SR_SET : SR_RESET;
    end
  end

endmodule

// File: rtl/srff_driver.sv
// Initiator for a clocked SR flip-flop: accepts a target bit, pulses the
// matching s/r excitation for one clock, settles, then verifies q/qb.
// Ports: clk, rst_n; tgt_valid/tgt_bit/tgt_ready handshake; s, r to the
// flip-flop; q_fb, qb_fb feedback; done/err per-transfer pulses;
// xfer_cnt/err_cnt saturating counters.
module srff_driver
  import srff_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             qb_fb,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned WCNT_W = $clog2(SETTLE + 1);

  state_e            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic              s_q, s_d;
  logic              r_q, r_d;
  logic              tgt_ready_q, tgt_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] sr_c;
  logic       pass_c;

  // Excitation is derived from the live feedback at the handshake edge.
  srff_excite u_excite (
    .q    (q_fb),
    .tgt  (tgt_bit),
    .sr_c (sr_c)
  );

  // Both rails must agree with the target; X/Z on either counts as a fail.
  assign pass_c = (q_fb === tgt_q) && (qb_fb === ~tgt_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    s_d         = 1'b0;
    r_d         = 1'b0;
    tgt_ready_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    xfer_cnt_d  = xfer_cnt_q;
    err_cnt_d   = err_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      IDLE: begin
        tgt_ready_d = 1'b1;
        if (tgt_valid && tgt_ready_q) begin
          tgt_d       = tgt_bit;
          {s_d, r_d}  = sr_c;
          tgt_ready_d = 1'b0;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        // s/r were loaded on entry; defaults release them on this exit edge.
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == WCNT_W'(SETTLE - 1)) begin
          state_d = CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      CHECK: begin
        done_d      = 1'b1;
        err_d       = ~pass_c;
        tgt_ready_d = 1'b1;
        state_d     = IDLE;
        if (xfer_cnt_q != '1) begin
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
        if (!pass_c && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      tgt_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      xfer_cnt_q  <= '0;
      err_cnt_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      tgt_ready_q <= tgt_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_cnt_q   <= err_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign tgt_ready = tgt_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_srff_driver.sv
// Directed bench for srff_driver: two instances (CNT_W=8 and CNT_W=2) each
// driving a behavioural SR flip-flop that powers up with q=1.
module tb_srff_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tgt_valid = 1'b0;
  logic tgt_bit = 1'b0;
  logic stuck = 1'b0;

  logic       tgt_ready, s1, r1, done, err;
  logic [7:0] xfer_cnt, err_cnt;
  logic       tgt_ready2, s2, r2, done2, err2;
  logic [1:0] xfer_cnt2, err_cnt2;

  logic q1 = 1'b1;
  logic q2 = 1'b1;
  logic q_fb1, qb_fb1;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int done_mark;

  always #5 clk = ~clk;

  // Flip-flop models; stuck pins dut's observed q to 0.
  always @(posedge clk) begin
    if (s1) q1 <= 1'b1;
    else if (r1) q1 <= 1'b0;
    if (s2) q2 <= 1'b1;
    else if (r2) q2 <= 1'b0;
  end
  assign q_fb1  = stuck ? 1'b0 : q1;
  assign qb_fb1 = ~q1;

  srff_driver #(.CNT_W(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready), .s(s1), .r(r1), .q_fb(q_fb1), .qb_fb(qb_fb1),
    .done(done), .err(err), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
  );

  srff_driver #(.CNT_W(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready2), .s(s2), .r(r2), .q_fb(q2), .qb_fb(~q2),
    .done(done2), .err(err2), .xfer_cnt(xfer_cnt2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // s and r must never be high together on either instance.
  always @(negedge clk) begin
    chk("sr_legal1", 32'(s1 & r1), 32'd0);
    chk("sr_legal2", 32'(s2 & r2), 32'd0);
    if (done === 1'b1) done_seen++;
  end

  // One full transfer starting in a cycle with tgt_ready high; ends in the done cycle.
  task automatic xfer(input logic tb, input logic [1:0] exp_sr, input logic exp_err);
    chk("hs_ready", 32'(tgt_ready), 32'd1);
    tgt_valid = 1'b1;
    tgt_bit   = tb;
    step();
    tgt_valid = 1'b0;
    tgt_bit   = ~tb;
    chk("drive_sr", 32'({s1, r1}), 32'(exp_sr));
    chk("drive_ready", 32'(tgt_ready), 32'd0);
    chk("drive_done", 32'(done), 32'd0);
    step();
    chk("wait_sr", 32'({s1, r1}), 32'd0);
    step();
    chk("check_done", 32'(done), 32'd0);
    step();
    chk("done", 32'(done), 32'd1);
    chk("err", 32'(err), 32'(exp_err));
    chk("done_ready", 32'(tgt_ready), 32'd1);
    chk("done2", 32'(done2), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_sr", 32'({s1, r1}), 32'd0);
    chk("rst_ready", 32'(tgt_ready), 32'd0);
    chk("rst_xfer", 32'(xfer_cnt), 32'd0);
    chk("rst_errc", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    chk("rel_ready", 32'(tgt_ready), 32'd0);
    step();
    chk("first_edge_ready", 32'(tgt_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sr6 [5];
    logic       tg6 [5];

    // 1: reset from power-up, q=1.
    #1;
    do_reset();
    chk("rst_done", 32'(done), 32'd0);

    // 2: target 0 from q=1 -> reset excitation.
    xfer(1'b0, 2'b01, 1'b0);
    chk("t2_q", 32'(q_fb1), 32'd0);
    chk("t2_xfer", 32'(xfer_cnt), 32'd1);

    // 3: set then hold, back to back.
    xfer(1'b1, 2'b10, 1'b0);
    xfer(1'b1, 2'b00, 1'b0);
    chk("t3_errc", 32'(err_cnt), 32'd0);
    chk("t3_xfer", 32'(xfer_cnt), 32'd3);

    // 4: q stuck at 0, target 1 -> set, flagged error.
    step();
    do_reset();
    stuck = 1'b1;
    xfer(1'b1, 2'b10, 1'b1);
    chk("t4_errc", 32'(err_cnt), 32'd1);
    chk("t4_xfer", 32'(xfer_cnt), 32'd1);
    stuck = 1'b0;
    step();

    // 5a: abort during DRIVE; r must fall without waiting for a clock.
    tgt_valid = 1'b1;
    tgt_bit   = 1'b0;
    step();
    tgt_valid = 1'b0;
    chk("t5_drive_r", 32'({s1, r1}), 32'b01);
    rst_n = 1'b0;
    #1;
    chk("t5_async_sr", 32'({s1, r1}), 32'd0);
    chk("t5_async_xfer", 32'(xfer_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5a_ready", 32'(tgt_ready), 32'd1);

    // 5b: abort during WAIT; no done may follow.
    tgt_valid = 1'b1;
    tgt_bit   = 1'b0;
    step();
    tgt_valid = 1'b0;
    step();
    done_mark = done_seen;
    rst_n = 1'b0;
    #1;
    chk("t5_wait_sr", 32'({s1, r1}), 32'd0);
    chk("t5_wait_ready", 32'(tgt_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("t5_rel_ready", 32'(tgt_ready), 32'd0);
    step();
    chk("t5_edge_ready", 32'(tgt_ready), 32'd1);
    step();
    step();
    step();
    chk("t5_no_done", 32'(done_seen), 32'(done_mark));
    chk("t5_xfer", 32'(xfer_cnt), 32'd0);

    // 6: five transfers; narrow counter saturates at 3. q starts at 0.
    do_reset();
    tg6 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sr6 = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 5; i++) begin
      xfer(tg6[i], sr6[i], 1'b0);
      chk("t6_xfer2", 32'(xfer_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
      chk("t6_err2", 32'(err2), 32'd0);
    end
    chk("t6_xfer", 32'(xfer_cnt), 32'd5);
    chk("t6_errc2", 32'(err_cnt2), 32'd0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
